adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares one 8-bit two's-complement adder/overflow datapath among NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Single shared response channel tagged with the requester id.
- Sits between the operand-producing units and the adder; the adder is instantiated internally and used one operation at a time.

Parameters:
WIDTH, 8, operand/sum width in bits (signed two's complement)
NREQ, 4, number of requesters (2..8)
IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B, same packing as req_a
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of requester that owns the response
rsp_sum  output  WIDTH  sum (low WIDTH bits, or saturated value)
rsp_over  output  1  signed overflow flag
busy  output  1  high whenever state != IDLE
op_count  output  CNTW  number of completed responses; wraps at 2**CNTW

Behaviour:
- Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_over=0, op_count=0, last_grant=NREQ-1 (requester 0 has first priority). Reset in any state aborts the operation in progress; no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE, arbitration:
  - If any req_valid, grant g = first i with req_valid[i] set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in this cycle only. The handshake completes in the same cycle.
  - At the edge, latch req_a[g], req_b[g] and g; go to CALC.
  - No valid requests: stay in IDLE, req_ready=0.
- req_ready is 0 in CALC and RESP. Requests held high there must stay pending; their operands are sampled only at their own grant.
- CALC:
  - Compute the sum at full WIDTH+1 bits.
  - rsp_over = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). Carry-out is ignored.
  - Register rsp_sum, rsp_over, rsp_id=g; go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_over and rsp_id are held stable until accepted.
  - On rsp_ready: last_grant=g, op_count+1 (wrap), rsp_valid=0 at next edge, go to IDLE.
  - rsp_ready while not in RESP is ignored.
- Latency: grant cycle T gives rsp_valid=1 at T+2. Minimum 3 cycles per operation when rsp_ready is held high.
- Fairness: a continuously requesting requester is granted within NREQ operations.
- last_grant updates only on response acceptance. Reset mid-RESP leaves the pointer at its reset value.

Optional Feature:
ADDER_SAT_EN
- Defined: on overflow, rsp_sum saturates to the most-positive value (0x7F for WIDTH=8) if both operands are non-negative, else the most-negative value (0x80). rsp_over is still 1.
- Undefined: rsp_sum wraps to the low WIDTH bits; no saturation logic is present.

Test Plan:
1. Reset, then req_valid=4'b0001, a0=0xB2, b0=0xEF -> req_ready=0001 for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=0xA1, rsp_over=0; op_count=1 after accept.
2. Requester 1: a=0x92, b=0x87 -> rsp_sum=0x19, rsp_over=1 (0x80 with ADDER_SAT_EN). Requester 2: a=0x32, b=0x6F -> rsp_sum=0xA1, rsp_over=1 (0x7F with ADDER_SAT_EN).
3. All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0; each response 3 cycles apart; rsp_id sequence matches.
4. rsp_ready=0 for 5 cycles in RESP (a=0x03, b=0xAF) -> rsp_valid stays 1 with rsp_sum=0xB2, rsp_over=0 held stable; req_ready stays 0; no new grant until accepted.
5. rst asserted during CALC -> next cycle all outputs at reset values, op_count=0. The next grant goes to requester 0 even if requester 3 is also valid.
6. op_count preloaded near wrap via 2**CNTW accepted operations (or CNTW=4 build: 16 ops) -> op_count returns to 0.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the operand producers and the shared adder.
// The producer side uses the master modport; the arbiter uses the slave modport.
interface adder_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_over;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_over
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_over
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one signed WIDTH-bit adder with
// overflow detection among NREQ requesters. One operation is in flight at a time:
// IDLE (arbitrate + accept operands) -> CALC (add) -> RESP (hold until consumed).
// Optional build macro ADDER_SAT_EN: when defined, an overflowing sum is replaced
// by the most-positive / most-negative representable value; rsp_over stays set.

// Invariant checks kept apart from the datapath; ignored by synthesis flows.
module adder_share_arbiter_chk #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [NREQ-1:0]  req_ready,
  input logic             busy,
  input logic             rsp_valid,
  input logic             rsp_ready,
  input logic [IDW-1:0]   rsp_id,
  input logic [WIDTH-1:0] rsp_sum,
  input logic             rsp_over,
  input logic [WIDTH:0]   sum_full,
  input logic             over
);
  // At most one requester is ever accepted in a cycle.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  // Nothing is accepted while an operation is in flight.
  a_ready_idle: assert property (@(posedge clk) disable iff (rst) busy |-> (req_ready == '0));

  // A stalled response keeps its payload until it is consumed.
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_sum) && $stable(rsp_over)));

  // Sign-bit overflow rule agrees with the extended-sum view (top two bits differ).
  a_ovf_consistent: assert property (@(posedge clk) disable iff (rst)
    over == (sum_full[WIDTH] ^ sum_full[WIDTH-1]));
endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 3,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Sign-extend both operands and add at WIDTH+1 bits.
  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {x[WIDTH-1], x} + {y[WIDTH-1], y};
  endfunction

  // Signed overflow: like-signed operands producing a differently-signed result.
  function automatic logic signed_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

`ifdef ADDER_SAT_EN
  // Clamp value chosen by the common operand sign.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  state_t            state_r;
  logic [IDW-1:0]    last_grant_r;
  logic [IDW-1:0]    grant_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [IDW-1:0]    rsp_id_r;
  logic [WIDTH-1:0]  rsp_sum_r;
  logic              rsp_over_r;
  logic              rsp_valid_r;
  logic              busy_r;
  logic [CNTW-1:0]   op_count_r;

  logic [IDW-1:0]    grant_s;
  logic              found_s;
  logic              take_s;
  logic [NREQ-1:0]   ready_s;
  logic [WIDTH-1:0]  sel_a_s;
  logic [WIDTH-1:0]  sel_b_s;
  logic [WIDTH:0]    sum_full_s;
  logic              over_s;
  logic [WIDTH-1:0]  result_s;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        take_s  = !found_s && bus.req_valid[i] && (((int'(last_grant_r) + k) % NREQ) == i);
        grant_s = take_s ? IDW'(i) : grant_s;
        found_s = found_s | take_s;
      end
    end
  end

  // Ready goes to the winner only while idle; the handshake completes this cycle.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready_s[i] = (state_r == IDLE) && found_s && (grant_s == IDW'(i));
    end
  end

  assign bus.req_ready = ready_s;

  // Operand mux: AND-OR select of the granted requester's lanes.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s = sel_a_s | ({WIDTH{grant_s == IDW'(i)}} & bus.req_a[i*WIDTH +: WIDTH]);
      sel_b_s = sel_b_s | ({WIDTH{grant_s == IDW'(i)}} & bus.req_b[i*WIDTH +: WIDTH]);
    end
  end

  // Shared adder on the latched operands; carry-out plays no part in the result.
  always_comb begin
    sum_full_s = add_ext(a_r, b_r);
    over_s     = signed_ovf(a_r, b_r, sum_full_s[WIDTH-1:0]);
`ifdef ADDER_SAT_EN
    result_s   = over_s ? sat_value(a_r[WIDTH-1]) : sum_full_s[WIDTH-1:0];
`else
    result_s   = sum_full_s[WIDTH-1:0];
`endif
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NREQ - 1);
      grant_r      <= '0;
      a_r          <= '0;
      b_r          <= '0;
      rsp_id_r     <= '0;
      rsp_sum_r    <= '0;
      rsp_over_r   <= 1'b0;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      op_count_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r <= grant_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            state_r <= CALC;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        CALC: begin
          rsp_sum_r   <= result_s;
          rsp_over_r  <= over_s;
          rsp_id_r    <= grant_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
          busy_r      <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            last_grant_r <= grant_r;
            op_count_r   <= op_count_r + {{(CNTW-1){1'b0}}, 1'b1};
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end else begin
            rsp_valid_r  <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_over  = rsp_over_r;
  assign busy          = busy_r;
  assign op_count      = op_count_r;

  adder_share_arbiter_chk #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_ready (ready_s),
    .busy      (busy_r),
    .rsp_valid (rsp_valid_r),
    .rsp_ready (bus.rsp_ready),
    .rsp_id    (rsp_id_r),
    .rsp_sum   (rsp_sum_r),
    .rsp_over  (rsp_over_r),
    .sum_full  (sum_full_s),
    .over      (over_s)
  );

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (NREQ=4, WIDTH=8, CNTW=4 so the
// counter wrap is reachable). Expected responses are queued when a grant is seen
// and compared when the response is consumed.
module tb_adder_share_arbiter;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] sum;
    logic       over;
  } rsp_t;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [3:0] op_count;
  int         n_chk;
  int         n_fail;
  rsp_t       exp_q[$];

  adder_share_arbiter_if #(.WIDTH(8), .NREQ(4), .IDW(3)) bus ();

  adder_share_arbiter #(
    .WIDTH (8),
    .NREQ  (4),
    .IDW   (3),
    .CNTW  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: integer sum, range check, optional clamp.
  function automatic rsp_t model(input int id, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    int   sa;
    int   sb;
    int   s;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
    r.id   = 3'(id);
    r.over = (s > 127) || (s < -128);
    r.sum  = s[7:0];
`ifdef ADDER_SAT_EN
    if (r.over) r.sum = (s > 0) ? 8'h7F : 8'h80;
`endif
    return r;
  endfunction

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r.id   = bus.rsp_id;
    r.sum  = bus.rsp_sum;
    r.over = bus.rsp_over;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 4'h0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drives one lone request with rsp_ready high; returns what was observed.
  task automatic single_op(input int i, input logic [7:0] a, input logic [7:0] b,
                           output logic [3:0] rdy, output rsp_t got, output int lat, output bit ok);
    set_ops(i, a, b);
    bus.req_valid = 4'b0001 << i;
    bus.rsp_ready = 1'b1;
    #1;
    rdy = bus.req_ready;
    tick();
    bus.req_valid = 4'h0;
    ok  = 1'b0;
    lat = -1;
    got = '0;
    for (int c = 0; c < 8 && !ok; c++) begin
      if (bus.rsp_valid) begin
        ok  = 1'b1;
        lat = c;
        got = cur_rsp();
      end else begin
        tick();
      end
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    n_chk++; if (bus.rsp_sum !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_sum: got %h want 00", bus.rsp_sum); end
    n_chk++; if (bus.rsp_over !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_over: got %b want 0", bus.rsp_over); end
    n_chk++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    rsp_t got, e;
    int lat;
    bit ok;
    exp_q.push_back('{id: 3'd0, sum: 8'hA1, over: 1'b0});
    single_op(0, 8'hB2, 8'hEF, rdy, got, lat, ok);
    n_chk++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", rdy); end
    n_chk++; if (!ok || lat != 1) begin n_fail++; $display("FAIL single_latency: got ok=%0d lat=%0d want lat=1", ok, lat); end
    e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL single_rsp: got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", got.id, got.sum, got.over, e.id, e.sum, e.over); end
    n_chk++; if (op_count !== 4'd1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_accept: got count=%0d valid=%b want 1,0", op_count, bus.rsp_valid); end
  endtask

  task automatic test_overflow();
    logic [3:0] rdy;
    rsp_t got, e;
    int lat;
    bit ok;
`ifdef ADDER_SAT_EN
    exp_q.push_back('{id: 3'd1, sum: 8'h80, over: 1'b1});
`else
    exp_q.push_back('{id: 3'd1, sum: 8'h19, over: 1'b1});
`endif
    single_op(1, 8'h92, 8'h87, rdy, got, lat, ok);
    n_chk++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL ovf_neg_ready: got %b want 0010", rdy); end
    e = exp_q.pop_front();
    n_chk++; if (!ok || got !== e) begin n_fail++; $display("FAIL ovf_neg_rsp: got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", got.id, got.sum, got.over, e.id, e.sum, e.over); end
`ifdef ADDER_SAT_EN
    exp_q.push_back('{id: 3'd2, sum: 8'h7F, over: 1'b1});
`else
    exp_q.push_back('{id: 3'd2, sum: 8'hA1, over: 1'b1});
`endif
    single_op(2, 8'h32, 8'h6F, rdy, got, lat, ok);
    n_chk++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL ovf_pos_ready: got %b want 0100", rdy); end
    e = exp_q.pop_front();
    n_chk++; if (!ok || got !== e) begin n_fail++; $display("FAIL ovf_pos_rsp: got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", got.id, got.sum, got.over, e.id, e.sum, e.over); end
    n_chk++; if (op_count !== 4'd3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", op_count); end
  endtask

  task automatic test_back_to_back();
    int ng, nr, last_gc, last_rc, gid, upd;
    bit stop;
    rsp_t e, got;
    do_reset();
    ng = 0; nr = 0; last_gc = 0; last_rc = 0; upd = -1; stop = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 60 && (ng < 5 || nr < 5); c++) begin
      #1;
      if (bus.req_ready != 4'h0) begin
        gid = -1;
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gid = i;
        n_chk++; if ($countones(bus.req_ready) != 1 || gid != ng % 4) begin n_fail++; $display("FAIL rr_order: grant #%0d got ready=%b want requester %0d", ng, bus.req_ready, ng % 4); end
        if (ng > 0) begin
          n_chk++; if (c - last_gc != 3) begin n_fail++; $display("FAIL rr_grant_spacing: got %0d cycles want 3", c - last_gc); end
        end
        exp_q.push_back(model(gid, bus.req_a[gid*8 +: 8], bus.req_b[gid*8 +: 8]));
        last_gc = c; upd = gid; ng++;
        if (ng == 5) stop = 1'b1;
      end
      if (bus.rsp_valid) begin
        got = cur_rsp();
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rr_rsp: unexpected response id=%0d sum=%h", got.id, got.sum);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL rr_rsp: got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", got.id, got.sum, got.over, e.id, e.sum, e.over); end
        end
        if (nr > 0) begin
          n_chk++; if (c - last_rc != 3) begin n_fail++; $display("FAIL rr_rsp_spacing: got %0d cycles want 3", c - last_rc); end
        end
        last_rc = c; nr++;
      end
      tick();
      if (upd >= 0) begin set_ops(upd, 8'($urandom), 8'($urandom)); upd = -1; end
      if (stop) bus.req_valid = 4'h0;
    end
    n_chk++; if (ng != 5 || nr != 5) begin n_fail++; $display("FAIL rr_counts: got grants=%0d rsps=%0d want 5,5", ng, nr); end
    n_chk++; if (op_count !== 4'd5) begin n_fail++; $display("FAIL rr_op_count: got %0d want 5", op_count); end
  endtask

  task automatic test_hold();
    rsp_t e, got;
    bus.rsp_ready = 1'b0;
    set_ops(0, 8'h03, 8'hAF);
    bus.req_valid = 4'b0001;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_grant: got %b want 0001", bus.req_ready); end
    exp_q.push_back('{id: 3'd0, sum: 8'hB2, over: 1'b0});
    tick();
    set_ops(1, 8'h11, 8'h22);
    bus.req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 8'hB2 || bus.rsp_over !== 1'b0 || bus.rsp_id !== 3'd0 || bus.req_ready !== 4'h0) begin
        n_fail++; $display("FAIL hold_stable: cycle %0d got valid=%b sum=%h over=%b id=%0d ready=%b want 1,b2,0,0,0000", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_over, bus.rsp_id, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    got = cur_rsp();
    e = exp_q.pop_front();
    n_chk++; if (bus.rsp_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL hold_rsp: got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", got.id, got.sum, got.over, e.id, e.sum, e.over); end
    tick();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_next_grant: got %b want 0010", bus.req_ready); end
    exp_q.push_back(model(1, 8'h11, 8'h22));
    tick();
    bus.req_valid = 4'h0;
    for (int c = 0; c < 8 && !bus.rsp_valid; c++) tick();
    got = cur_rsp();
    e = exp_q.pop_front();
    n_chk++; if (bus.rsp_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL hold_pending_rsp: got valid=%b id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", bus.rsp_valid, got.id, got.sum, got.over, e.id, e.sum, e.over); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_t e, got;
    set_ops(2, 8'h55, 8'h12);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b1001;
    set_ops(0, 8'h40, 8'h3F);
    set_ops(3, 8'h01, 8'h01);
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 8'h00 || bus.rsp_over !== 1'b0 || bus.rsp_id !== 3'd0) begin n_fail++; $display("FAIL midrst_rsp: got valid=%b sum=%h over=%b id=%0d want all 0", bus.rsp_valid, bus.rsp_sum, bus.rsp_over, bus.rsp_id); end
    n_chk++; if (op_count !== 4'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", op_count); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_priority: got %b want 0001", bus.req_ready); end
    exp_q.push_back(model(0, 8'h40, 8'h3F));
    tick();
    bus.req_valid = 4'h0;
    for (int c = 0; c < 8 && !bus.rsp_valid; c++) tick();
    got = cur_rsp();
    e = exp_q.pop_front();
    n_chk++; if (bus.rsp_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL midrst_rsp_after: got valid=%b id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", bus.rsp_valid, got.id, got.sum, got.over, e.id, e.sum, e.over); end
    tick();
    tick();
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b0 || op_count !== 4'd1) begin n_fail++; $display("FAIL midrst_no_stale: got valid=%b count=%0d want 0,1", bus.rsp_valid, op_count); end
  endtask

  task automatic test_count_wrap();
    logic [3:0] rdy;
    rsp_t got, e;
    int lat;
    bit ok;
    logic [7:0] a, b;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp_q.push_back(model(k % 4, a, b));
      single_op(k % 4, a, b, rdy, got, lat, ok);
      e = exp_q.pop_front();
      n_chk++; if (rdy !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL wrap_ready: op %0d got %b", k, rdy); end
      n_chk++; if (!ok || got !== e) begin n_fail++; $display("FAIL wrap_rsp: op %0d got id=%0d sum=%h over=%b want id=%0d sum=%h over=%b", k, got.id, got.sum, got.over, e.id, e.sum, e.over); end
      n_chk++; if (op_count !== 4'((k + 1) % 16)) begin n_fail++; $display("FAIL wrap_count: op %0d got %0d want %0d", k, op_count, (k + 1) % 16); end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
